// File: rtl/mul_pkg.sv
// Shared types for the sequential multiplier: FSM states and Booth op codes.
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Unsigned mode adds when the multiplier bit is set; signed mode uses the
  // Booth radix-2 pair {lo[0], q_m1}.
  function automatic booth_op_t booth_decode(input logic lsb, input logic q_m1,
                                             input logic is_signed);
    booth_op_t op;
    op = OP_NOP;
    if (!is_signed) begin
      if (lsb) op = OP_ADD;
    end else begin
      case ({lsb, q_m1})
        2'b01:   op = OP_ADD;
        2'b10:   op = OP_SUB;
        default: op = OP_NOP;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add / Booth iteration on the {hi, lo, q_m1} accumulator.
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic             is_signed,
  output logic [WIDTH:0]   hi_next,
  output logic [WIDTH-1:0] lo_next,
  output logic             q_next
);

  booth_op_t       op;
  logic [WIDTH:0]  ext;
  logic [WIDTH:0]  sum;
  logic            fill;

  // Add/subtract the extended multiplicand into hi, then shift {hi,lo} right;
  // hi is one bit wider than the operands so neither mode can overflow.
  always_comb begin
    op   = booth_decode(lo[0], q_m1, is_signed);
    ext  = is_signed ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
    sum  = hi;
    case (op)
      OP_ADD:  sum = hi + ext;
      OP_SUB:  sum = hi - ext;
      default: sum = hi;
    endcase
    fill    = is_signed & sum[WIDTH];
    hi_next = {fill, sum[WIDTH:1]};
    lo_next = {sum[0], lo[WIDTH-1:1]};
    q_next  = lo[0];
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Sequential multiplier: unsigned shift-add or signed Booth radix-2,
// one iteration per cycle, with captured operands and a held product.
module seq_mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic [2*WIDTH-1:0] Product,
  output logic               Ready,
  output logic               Busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     hi;
  logic [WIDTH-1:0]   lo;
  logic               q_m1;
  logic [WIDTH-1:0]   mcand_r;
  logic               signed_r;
  logic [WIDTH:0]     hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic               q_next;
  logic               accept;
  logic               last_iter;

  assign accept    = Run && (state == S_IDLE || state == S_DONE);
  assign last_iter = (state == S_CALC) && (cnt == LAST_ITER);
  assign Ready     = (state == S_DONE);
  assign Busy      = (state == S_CALC);

  mul_step #(.WIDTH(WIDTH)) u_step (
    .hi           (hi),
    .lo           (lo),
    .q_m1         (q_m1),
    .multiplicand (mcand_r),
    .is_signed    (signed_r),
    .hi_next      (hi_next),
    .lo_next      (lo_next),
    .q_next       (q_next)
  );

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state: start from IDLE/DONE, stay in CALC until the last iteration.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_CALC;
      S_CALC:  if (last_iter) next_state = S_DONE;
      S_DONE:  if (accept) next_state = S_CALC;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate in CALC, publish on the last step.
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      q_m1     <= 1'b0;
      mcand_r  <= '0;
      signed_r <= 1'b0;
      Product  <= '0;
    end else if (accept) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= Multiplier;
      q_m1     <= 1'b0;
      mcand_r  <= Multiplicand;
      signed_r <= Signed;
    end else if (state == S_CALC) begin
      cnt  <= cnt + CNT_W'(1);
      hi   <= hi_next;
      lo   <= lo_next;
      q_m1 <= q_next;
      if (last_iter) Product <= {hi_next[WIDTH-1:0], lo_next};
    end
  end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed self-checking bench for seq_mul_unit at WIDTH=8 and WIDTH=32.
module tb_seq_mul_unit;

  logic        clk;
  logic        reset;

  logic        run8, signed8;
  logic [7:0]  mcand8, mplier8;
  logic [15:0] product8;
  logic        ready8, busy8;

  logic        run32, signed32;
  logic [31:0] mcand32, mplier32;
  logic [63:0] product32;
  logic        ready32, busy32;

  int checks;
  int passes;

  seq_mul_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .Reset(reset), .Run(run8), .Signed(signed8),
    .Multiplicand(mcand8), .Multiplier(mplier8),
    .Product(product8), .Ready(ready8), .Busy(busy8)
  );

  seq_mul_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .Reset(reset), .Run(run32), .Signed(signed32),
    .Multiplicand(mcand32), .Multiplier(mplier32),
    .Product(product32), .Ready(ready32), .Busy(busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one 8-bit op and wait (bounded) for Ready; lat = -1 on timeout.
  task automatic run_op8(input logic [7:0] mc, input logic [7:0] mp, input logic sg,
                         output logic [15:0] prod, output int lat);
    mcand8 = mc; mplier8 = mp; signed8 = sg; run8 = 1'b1;
    tick();
    run8 = 1'b0;
    lat = 0;
    while (!ready8 && lat < 40) begin
      tick();
      lat++;
    end
    if (!ready8) lat = -1;
    prod = product8;
  endtask

  task automatic run_op32(input logic [31:0] mc, input logic [31:0] mp, input logic sg,
                          output logic [63:0] prod, output int lat);
    mcand32 = mc; mplier32 = mp; signed32 = sg; run32 = 1'b1;
    tick();
    run32 = 1'b0;
    lat = 0;
    while (!ready32 && lat < 80) begin
      tick();
      lat++;
    end
    if (!ready32) lat = -1;
    prod = product32;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (product8 !== 16'h0000) $display("[TB] FAIL reset_product: got %h want 0000", product8); else passes++;
    checks++; if (ready8 !== 1'b0) $display("[TB] FAIL reset_ready: got %b want 0", ready8); else passes++;
    checks++; if (busy8 !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy8); else passes++;
    checks++; if (product32 !== 64'h0) $display("[TB] FAIL reset_product32: got %h want 0", product32); else passes++;
  endtask

  task automatic test_unsigned();
    int lat;
    mcand8 = 8'd200; mplier8 = 8'd150; signed8 = 1'b0; run8 = 1'b1;
    tick();
    run8 = 1'b0;
    checks++; if (busy8 !== 1'b1 || ready8 !== 1'b0) $display("[TB] FAIL accept_flags: busy=%b ready=%b want busy=1 ready=0", busy8, ready8); else passes++;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (ready8 !== 1'b0) $display("[TB] FAIL ready_early: ready=%b at 7 cycles want 0", ready8); else passes++;
    tick();
    checks++; if (ready8 !== 1'b1 || busy8 !== 1'b0) $display("[TB] FAIL ready_at_8: ready=%b busy=%b want ready=1 busy=0", ready8, busy8); else passes++;
    checks++; if (product8 !== 16'h7530) $display("[TB] FAIL unsigned_200x150: got %h want 7530", product8); else passes++;
    tick(); tick();
    checks++; if (product8 !== 16'h7530 || ready8 !== 1'b1) $display("[TB] FAIL done_hold: product=%h ready=%b want 7530/1", product8, ready8); else passes++;
    lat = 0;
  endtask

  task automatic test_reset_idle();
    run8 = 1'b1; mcand8 = 8'd3; mplier8 = 8'd3;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; run8 = 1'b0;
    checks++; if (product8 !== 16'h0000) $display("[TB] FAIL idle_reset_product: got %h want 0000", product8); else passes++;
    checks++; if (ready8 !== 1'b0 || busy8 !== 1'b0) $display("[TB] FAIL idle_reset_flags: ready=%b busy=%b want 0/0", ready8, busy8); else passes++;
  endtask

  task automatic test_signed();
    logic [15:0] p;
    int lat;
    run_op8(8'hFD, 8'h05, 1'b1, p, lat);
    checks++; if (p !== 16'hFFF1 || lat != 8) $display("[TB] FAIL signed_fd_x_05: got %h lat %0d want fff1 lat 8", p, lat); else passes++;
    run_op8(8'hFD, 8'h05, 1'b0, p, lat);
    checks++; if (p !== 16'h04F1 || lat != 8) $display("[TB] FAIL unsigned_fd_x_05: got %h lat %0d want 04f1 lat 8", p, lat); else passes++;
    run_op8(8'h80, 8'h80, 1'b1, p, lat);
    checks++; if (p !== 16'h4000 || lat != 8) $display("[TB] FAIL signed_80_x_80: got %h lat %0d want 4000 lat 8", p, lat); else passes++;
    run_op8(8'h7F, 8'h80, 1'b1, p, lat);
    checks++; if (p !== 16'hC080 || lat != 8) $display("[TB] FAIL signed_7f_x_80: got %h lat %0d want c080 lat 8", p, lat); else passes++;
  endtask

  task automatic test_width32();
    logic [63:0] p;
    int lat;
    run_op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, p, lat);
    checks++; if (p !== 64'hFFFFFFFE00000001 || lat != 32) $display("[TB] FAIL w32_unsigned: got %h lat %0d want fffffffe00000001 lat 32", p, lat); else passes++;
    run_op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, p, lat);
    checks++; if (p !== 64'h1 || lat != 32) $display("[TB] FAIL w32_signed: got %h lat %0d want 1 lat 32", p, lat); else passes++;
  endtask

  task automatic test_back_to_back();
    int lat;
    int period;
    mcand8 = 8'd3; mplier8 = 8'd4; signed8 = 1'b0; run8 = 1'b1;
    tick();
    lat = 0;
    while (!ready8 && lat < 40) begin tick(); lat++; end
    checks++; if (product8 !== 16'h000C || lat != 8) $display("[TB] FAIL b2b_first: got %h lat %0d want 000c lat 8", product8, lat); else passes++;
    mcand8 = 8'd5; mplier8 = 8'd6;
    tick();
    period = 1;
    checks++; if (ready8 !== 1'b0 || busy8 !== 1'b1) $display("[TB] FAIL b2b_ready_pulse: ready=%b busy=%b want 0/1", ready8, busy8); else passes++;
    while (!ready8 && period < 40) begin tick(); period++; end
    run8 = 1'b0;
    checks++; if (period != 9) $display("[TB] FAIL b2b_period: got %0d want 9", period); else passes++;
    checks++; if (product8 !== 16'h001E) $display("[TB] FAIL b2b_second: got %h want 001e", product8); else passes++;
  endtask

  task automatic test_capture();
    mcand8 = 8'd7; mplier8 = 8'd9; signed8 = 1'b0; run8 = 1'b1;
    tick();
    run8 = 1'b0;
    mcand8 = 8'hFF; mplier8 = 8'hFF; signed8 = 1'b1;
    tick(); tick();
    run8 = 1'b1;
    tick();
    run8 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (ready8 !== 1'b1 || product8 !== 16'h003F) $display("[TB] FAIL capture: ready=%b product=%h want 1/003f", ready8, product8); else passes++;
  endtask

  task automatic test_reset_calc();
    logic [15:0] p;
    int lat;
    mcand8 = 8'd11; mplier8 = 8'd13; signed8 = 1'b0; run8 = 1'b1;
    tick();
    run8 = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (product8 !== 16'h0000 || ready8 !== 1'b0 || busy8 !== 1'b0) $display("[TB] FAIL calc_reset: product=%h ready=%b busy=%b want 0000/0/0", product8, ready8, busy8); else passes++;
    tick(); tick();
    checks++; if (busy8 !== 1'b0 || ready8 !== 1'b0) $display("[TB] FAIL calc_reset_stays_idle: busy=%b ready=%b want 0/0", busy8, ready8); else passes++;
    run_op8(8'd7, 8'd6, 1'b0, p, lat);
    checks++; if (p !== 16'h002A || lat != 8) $display("[TB] FAIL after_reset_7x6: got %h lat %0d want 002a lat 8", p, lat); else passes++;
  endtask

  initial begin
    checks = 0; passes = 0;
    reset = 1'b1;
    run8 = 1'b0; signed8 = 1'b0; mcand8 = '0; mplier8 = '0;
    run32 = 1'b0; signed32 = 1'b0; mcand32 = '0; mplier32 = '0;
    test_reset();
    test_unsigned();
    test_reset_idle();
    test_signed();
    test_width32();
    test_back_to_back();
    test_capture();
    test_reset_calc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_mul_unit.md
# seq_mul_unit

Parametrised sequential multiplier, successor to the fixed 32-bit shift-add `Control`/datapath pair. It bundles the control FSM and the product datapath into one block. It adds a run-time signed (Booth radix-2) mode, operand capture and a held result register. It sits beside the ALU and is started by the core's `Run` strobe.

## Interface
- `WIDTH`, default 32: operand width, legal range ≥ 2.
- `CNT_W`, derived localparam `$clog2(WIDTH+1)`: width of the iteration counter.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `Reset` input, 1 bit: synchronous, active-high reset.
- `Run` input, 1 bit: start request, sampled in IDLE/DONE only.
- `Signed` input, 1 bit: 0 = unsigned shift-add, 1 = two's-complement Booth radix-2. Latched at accept.
- `Multiplicand` input, WIDTH bits: captured at accept.
- `Multiplier` input, WIDTH bits: captured at accept.
- `Product` output, 2*WIDTH bits: last completed result, registered.
- `Ready` output, 1 bit: result valid; high in DONE only.
- `Busy` output, 1 bit: high in CALC only.

## Operation
- FSM states: IDLE, CALC, DONE.
- Reset values: state IDLE, `Product`=0, `Ready`=0, `Busy`=0, counter 0, accumulator 0, Booth bit 0.
- **Accept:** in IDLE or DONE, `Run`=1 at an edge causes the following at that edge:
  - capture `Multiplicand`, `Multiplier` and `Signed`;
  - hi accumulator (WIDTH+1 bits) := 0, lo := `Multiplier`, Booth bit q₋₁ := 0, counter := 0;
  - move to CALC.
- **CALC:** one iteration per cycle; counter increments each iteration.
  - Unsigned: if lo[0]=1, hi := hi + zero-extended multiplicand. Then shift {hi,lo} right by 1 with 0 in.
  - Signed: {lo[0],q₋₁}=01 adds and 10 subtracts the sign-extended multiplicand; 00 and 11 make no change. Then q₋₁ := lo[0] and {hi,lo} shifts arithmetically right by 1.
  - hi is WIDTH+1 bits, so unsigned carry and signed −2^(WIDTH−1) operands never overflow.
- **Completion:** after iteration WIDTH, `Product` := low 2*WIDTH bits of {hi,lo} and the state goes to DONE.
- **DONE:** `Ready`=1, and `Product` holds until the next completion. A new accept leaves DONE.
- `Run` and operand changes during CALC are ignored.
- **Reset mid-operation:** aborts the current operation. All state and outputs return to reset values at that edge, including `Product`=0.
- Reset has priority over `Run` when both are high at the same edge.

## Timing
- Accept edge k: `Busy`=1 after k.
- Iterations occur on edges k+1 … k+WIDTH.
- At edge k+WIDTH: `Product` updates, `Ready`=1, `Busy`=0.
- Latency from accept to `Ready` is WIDTH cycles.
- `Ready` falls on the edge that accepts a new `Run`.
- With `Run` held high, `Ready` pulses for 1 cycle and the throughput is one result per WIDTH+1 cycles.
- `Busy` and `Ready` are never both high. Both are low only in IDLE.
- No combinational path from inputs to outputs.

## Structure
- Package `mul_pkg` holds:
  - state encoding localparams `S_IDLE`=2'd0, `S_CALC`=2'd1, `S_DONE`=2'd2;
  - Booth op codes `OP_NOP`, `OP_ADD`, `OP_SUB`.
- One combinational sub-module, `mul_step`:
  - inputs: hi, lo, q₋₁, multiplicand, signed flag;
  - outputs: next hi, next lo, next q₋₁.
- FSM, counter and output registers live in `seq_mul_unit`.

## Test plan
- **Reset:** assert `Reset` 2 cycles mid-idle → `Product`=0, `Ready`=0, `Busy`=0.
- **Unsigned, WIDTH=8:** 200×150 (Signed=0) → `Product`=16'h7530, with `Ready` rising exactly 8 cycles after the accept edge.
- **Signed, WIDTH=8:**
  - 8'hFD×8'h05 (Signed=1) → 16'hFFF1.
  - The same operands with Signed=0 → 16'h04F1.
  - 8'h80×8'h80 signed → 16'h4000.
- **WIDTH=32:** 32'hFFFFFFFF×32'hFFFFFFFF.
  - Unsigned → 64'hFFFFFFFE00000001.
  - Signed → 64'h1.
- **Back-to-back and operand capture:**
  - Hold `Run`=1 over two ops → `Ready` high for exactly 1 cycle between them, period WIDTH+1.
  - Change operands during CALC → result unaffected.
- **Reset during CALC (iteration 3):** outputs return to 0 on that edge. A following 7×6 unsigned op → 16'h002A after 8 cycles.
